uart_rx: RTL

Serial receiver for the 8N1 UART link, paired with the `uart_tx` transmitter.
- Synchronises the asynchronous `i_Rx_Serial` line into the `i_Clock` domain.
- Detects the start bit, samples each bit at mid-bit, and presents the received byte with a one-cycle valid pulse.
- Flags framing errors, and parity errors when parity is compiled in.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_sync.sv | 26 ++
 rtl/uart_rx.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings (common to uart_tx and uart_rx),
// frame geometry, default bit period and counter width.
package uart_pkg;

  localparam int DATA_BITS        = 8;
  localparam int CLKS_PER_BIT_DEF = 87;
  localparam int CNT_W            = 11;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_CLEANUP   = 3'd5,
    ST_WAIT_HIGH = 3'd6
  } uart_state_e;

  // Even-parity bit for a data word (XOR of all bits).
  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous input; both flops reset to RST_VAL.
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_Clock,
  input  logic i_Rst_n,
  input  logic i_D,
  output logic o_Q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_D;
      r_sync <= r_meta;
    end
  end

  assign o_Q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and framing-error detection.
// Define UART_RX_PARITY_EN for 8E1 frames with a parity-error output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Active,
`ifdef UART_RX_PARITY_EN
  output logic       o_Rx_Parity_Err,
`endif
  output logic       o_Rx_Frame_Err
);

  localparam logic [CNT_W-1:0] LP_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic w_rx_s;

  uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
    .i_Clock (i_Clock),
    .i_Rst_n (i_Rst_n),
    .i_D     (i_Rx_Serial),
    .o_Q     (w_rx_s)
  );

  uart_state_e          r_state, w_state;
  logic [CNT_W-1:0]     r_cnt,   w_cnt;
  logic [2:0]           r_idx,   w_idx;
  logic [DATA_BITS-1:0] r_data,  w_data;
  logic [DATA_BITS-1:0] r_byte,  w_byte;
  logic                 r_dv,    w_dv;
  logic                 r_active, w_active;
  logic                 r_ferr,  w_ferr;
`ifdef UART_RX_PARITY_EN
  logic                 r_perr_flag, w_perr_flag;
  logic                 r_perr,  w_perr;
`endif

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_data      <= '0;
      r_byte      <= '0;
      r_dv        <= 1'b0;
      r_active    <= 1'b0;
      r_ferr      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr_flag <= 1'b0;
      r_perr      <= 1'b0;
`endif
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_idx       <= w_idx;
      r_data      <= w_data;
      r_byte      <= w_byte;
      r_dv        <= w_dv;
      r_active    <= w_active;
      r_ferr      <= w_ferr;
`ifdef UART_RX_PARITY_EN
      r_perr_flag <= w_perr_flag;
      r_perr      <= w_perr;
`endif
    end
  end

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_idx       = r_idx;
    w_data      = r_data;
    w_byte      = r_byte;
    w_dv        = 1'b0;
    w_active    = r_active;
    w_ferr      = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_perr_flag = r_perr_flag;
    w_perr      = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        w_cnt    = '0;
        w_idx    = '0;
        w_active = 1'b0;
        if (!w_rx_s) w_state = ST_START;
      end
      ST_START: begin
        if (r_cnt == LP_HALF) begin
          w_cnt = '0;
          // A start bit that is high again at mid-bit was only a glitch.
          if (!w_rx_s) begin
            w_state  = ST_DATA;
            w_active = 1'b1;
`ifdef UART_RX_PARITY_EN
            w_perr_flag = 1'b0;
`endif
          end else begin
            w_state = ST_IDLE;
          end
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (r_cnt == LP_LAST) begin
          w_cnt         = '0;
          w_data[r_idx] = w_rx_s;
          w_idx         = r_idx + 3'd1;
          if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state = ST_PARITY;
`else
            w_state = ST_STOP;
`endif
          end
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (r_cnt == LP_LAST) begin
          w_cnt       = '0;
          w_perr_flag = (w_rx_s != even_parity(r_data));
          w_state     = ST_STOP;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (r_cnt == LP_LAST) begin
          w_cnt    = '0;
          w_active = 1'b0;
          if (w_rx_s) begin
            w_state = ST_CLEANUP;
`ifdef UART_RX_PARITY_EN
            if (r_perr_flag) begin
              w_perr = 1'b1;
            end else begin
              w_byte = r_data;
              w_dv   = 1'b1;
            end
`else
            w_byte = r_data;
            w_dv   = 1'b1;
`endif
          end else begin
            // Low stop bit: wait for the line to go high so a break is not re-read as a start.
            w_ferr  = 1'b1;
            w_state = ST_WAIT_HIGH;
          end
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      ST_CLEANUP: begin
        w_state = ST_IDLE;
      end
      ST_WAIT_HIGH: begin
        if (w_rx_s) w_state = ST_IDLE;
      end
      default: begin
        w_state = ST_IDLE;
      end
    endcase
  end

  assign o_Rx_DV         = r_dv;
  assign o_Rx_Byte       = r_byte;
  assign o_Rx_Active     = r_active;
  assign o_Rx_Frame_Err  = r_ferr;
`ifdef UART_RX_PARITY_EN
  assign o_Rx_Parity_Err = r_perr;
`endif

endmodule
